mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response and shared-memory signals between the fetch and load/store
// requesters, the arbiter and the byte-addressable memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req_valid;
  logic                  if_req_ready;
  logic [ADDR_WIDTH-1:0] if_req_addr;
  logic                  if_resp_valid;
  logic [31:0]           if_resp_data;
  logic                  if_resp_err;

  logic                  ls_req_valid;
  logic                  ls_req_ready;
  logic [ADDR_WIDTH-1:0] ls_req_addr;
  logic                  ls_req_we;
  logic [1:0]            ls_req_size;
  logic                  ls_req_signed;
  logic [31:0]           ls_req_wdata;
  logic                  ls_resp_valid;
  logic [31:0]           ls_resp_data;
  logic                  ls_resp_err;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_write_data;
  logic [3:0]            mem_write_mask;
  logic [31:0]           mem_read_data;

  // Arbiter side.
  modport slave (
    input  if_req_valid, if_req_addr,
    input  ls_req_valid, ls_req_addr, ls_req_we, ls_req_size, ls_req_signed, ls_req_wdata,
    input  mem_read_data,
    output if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
    output ls_req_ready, ls_resp_valid, ls_resp_data, ls_resp_err,
    output mem_addr, mem_write_data, mem_write_mask
  );

  // Requesters plus memory side.
  modport master (
    output if_req_valid, if_req_addr,
    output ls_req_valid, ls_req_addr, ls_req_we, ls_req_size, ls_req_signed, ls_req_wdata,
    output mem_read_data,
    input  if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
    input  ls_req_ready, ls_resp_valid, ls_resp_data, ls_resp_err,
    input  mem_addr, mem_write_data, mem_write_mask
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one byte-addressable memory port between an
// instruction-fetch and a load/store requester; responses return one cycle later.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic { PRI_LS = 1'b0, PRI_IF = 1'b1 } prio_t;
  typedef enum logic [1:0] { SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11 } size_t;

  prio_t       prio_q;
  logic        grant_if, grant_ls;
  logic        if_misalign, ls_misalign;
  size_t       ls_size;
  logic [31:0] load_data;

  logic        if_valid_q, ls_valid_q;
  logic [31:0] if_data_q, ls_data_q;
  logic        if_err_q, ls_err_q;

  assign ls_size = size_t'(bus.ls_req_size);

  // A lone requester always wins; under contention the pointer decides.
  assign grant_ls = !reset && bus.ls_req_valid && (!bus.if_req_valid || prio_q == PRI_LS);
  assign grant_if = !reset && bus.if_req_valid && (!bus.ls_req_valid || prio_q == PRI_IF);

  assign bus.ls_req_ready = grant_ls;
  assign bus.if_req_ready = grant_if;

  assign if_misalign = bus.if_req_addr[1:0] != 2'b00;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ls_misalign = 1'b0;
    unique case (ls_size)
      SZ_BYTE: ls_misalign = 1'b0;
      SZ_HALF: ls_misalign = bus.ls_req_addr[0];
      SZ_WORD: ls_misalign = bus.ls_req_addr[1:0] != 2'b00;
      SZ_ILL:  ls_misalign = 1'b1;
    endcase
  end

  always_comb begin
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    bus.mem_write_mask = 4'b0000;
    if (grant_ls) begin
      bus.mem_addr       = bus.ls_req_addr;
      bus.mem_write_data = bus.ls_req_wdata;
      if (bus.ls_req_we && !ls_misalign) begin
        unique case (ls_size)
          SZ_BYTE: bus.mem_write_mask = 4'b0001;
          SZ_HALF: bus.mem_write_mask = 4'b0011;
          SZ_WORD: bus.mem_write_mask = 4'b1111;
          SZ_ILL:  bus.mem_write_mask = 4'b0000;
        endcase
      end
    end else if (grant_if) begin
      bus.mem_addr = bus.if_req_addr;
    end
  end

  // Sign/zero extension of the addressed low bytes; word loads ignore signed.
  always_comb begin
    load_data = bus.mem_read_data;
    unique case (ls_size)
      SZ_BYTE: load_data = {{24{bus.ls_req_signed & bus.mem_read_data[7]}}, bus.mem_read_data[7:0]};
      SZ_HALF: load_data = {{16{bus.ls_req_signed & bus.mem_read_data[15]}}, bus.mem_read_data[15:0]};
      SZ_WORD: load_data = bus.mem_read_data;
      SZ_ILL:  load_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      prio_q     <= PRI_LS;
      if_valid_q <= 1'b0;
      ls_valid_q <= 1'b0;
      if_data_q  <= '0;
      ls_data_q  <= '0;
      if_err_q   <= 1'b0;
      ls_err_q   <= 1'b0;
    end else begin
      if_valid_q <= grant_if;
      ls_valid_q <= grant_ls;
      if (grant_if) begin
        if_data_q <= if_misalign ? 32'h0 : bus.mem_read_data;
        if_err_q  <= if_misalign;
      end
      if (grant_ls) begin
        ls_data_q <= (ls_misalign || bus.ls_req_we) ? 32'h0 : load_data;
        ls_err_q  <= ls_misalign;
      end
      if (grant_ls)      prio_q <= PRI_IF;
      else if (grant_if) prio_q <= PRI_LS;
    end
  end

  // Reset in the response cycle drops the response immediately, not one cycle later.
  assign bus.if_resp_valid = if_valid_q && !reset;
  assign bus.ls_resp_valid = ls_valid_q && !reset;
  assign bus.if_resp_data  = if_data_q;
  assign bus.ls_resp_data  = ls_data_q;
  assign bus.if_resp_err   = if_err_q;
  assign bus.ls_resp_err   = ls_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 256-byte memory behind the shared
// port; expected values are hand-computed constants.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic preload;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem [256];
  logic [7:0] ra;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign ra = bus.mem_addr[7:0];
  assign bus.mem_read_data = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h00] <= 8'h13;
      mem[8'h04] <= 8'hEF;
      mem[8'h05] <= 8'hBE;
      mem[8'h06] <= 8'hAD;
      mem[8'h07] <= 8'hDE;
      mem[8'h20] <= 8'h80;
      mem[8'h21] <= 8'h01;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_write_mask[b]) mem[8'(ra + 8'(b))] <= bus.mem_write_data[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_if(input logic v, input logic [31:0] addr);
    bus.if_req_valid = v;
    bus.if_req_addr  = addr;
  endtask

  task automatic drive_ls(input logic v, input logic [31:0] addr, input logic we,
                          input logic [1:0] size, input logic sgn, input logic [31:0] wdata);
    bus.ls_req_valid  = v;
    bus.ls_req_addr   = addr;
    bus.ls_req_we     = we;
    bus.ls_req_size   = size;
    bus.ls_req_signed = sgn;
    bus.ls_req_wdata  = wdata;
  endtask

  initial begin
    reset   = 1'b1;
    preload = 1'b1;
    drive_if(1'b0, 32'h0);
    drive_ls(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0);
    tick();
    preload = 1'b0;

    // Reset: requests present but nothing granted.
    drive_if(1'b1, 32'h0);
    drive_ls(1'b1, 32'h4, 1'b0, 2'b10, 1'b0, 32'h0);
    settle();
    check("rst_if_ready", 32'(bus.if_req_ready), 32'd0);
    check("rst_ls_ready", 32'(bus.ls_req_ready), 32'd0);
    check("rst_mask",     32'(bus.mem_write_mask), 32'd0);
    tick();
    check("rst_if_resp_valid", 32'(bus.if_resp_valid), 32'd0);
    check("rst_ls_resp_valid", 32'(bus.ls_resp_valid), 32'd0);
    check("rst_if_resp_data",  bus.if_resp_data, 32'h0);
    check("rst_ls_resp_data",  bus.ls_resp_data, 32'h0);
    check("rst_if_resp_err",   32'(bus.if_resp_err), 32'd0);
    check("rst_ls_resp_err",   32'(bus.ls_resp_err), 32'd0);

    // Contention from reset: LS, IF, LS, IF.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("rr_ls_ready", 32'(bus.ls_req_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_if_ready", 32'(bus.if_req_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      check("rr_mem_addr", bus.mem_addr, (i % 2 == 0) ? 32'h4 : 32'h0);
      tick();
      check("rr_ls_resp_valid", 32'(bus.ls_resp_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_if_resp_valid", 32'(bus.if_resp_valid), (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i % 2 == 0) check("rr_ls_resp_data", bus.ls_resp_data, 32'hDEADBEEF);
      else            check("rr_if_resp_data", bus.if_resp_data, 32'h00000013);
    end

    // Byte store then signed/unsigned byte loads.
    drive_if(1'b0, 32'h0);
    drive_ls(1'b1, 32'h11, 1'b1, 2'b00, 1'b0, 32'h123456AB);
    settle();
    check("sb_ready",    32'(bus.ls_req_ready), 32'd1);
    check("sb_mem_addr", bus.mem_addr, 32'h11);
    check("sb_mask",     32'(bus.mem_write_mask), 32'b0001);
    check("sb_wdata",    bus.mem_write_data, 32'h123456AB);
    tick();
    check("sb_resp_valid", 32'(bus.ls_resp_valid), 32'd1);
    check("sb_resp_data",  bus.ls_resp_data, 32'h0);
    check("sb_resp_err",   32'(bus.ls_resp_err), 32'd0);
    check("hold_if_valid", 32'(bus.if_resp_valid), 32'd0);
    check("hold_if_data",  bus.if_resp_data, 32'h00000013);
    drive_ls(1'b1, 32'h11, 1'b0, 2'b00, 1'b1, 32'h0);
    tick();
    check("lb_signed", bus.ls_resp_data, 32'hFFFFFFAB);
    drive_ls(1'b1, 32'h11, 1'b0, 2'b00, 1'b0, 32'h0);
    tick();
    check("lb_unsigned", bus.ls_resp_data, 32'h000000AB);

    // Misaligned half store: accepted, no write, error response.
    drive_ls(1'b1, 32'h13, 1'b1, 2'b01, 1'b0, 32'hFFFFFFFF);
    settle();
    check("sh_mis_ready", 32'(bus.ls_req_ready), 32'd1);
    check("sh_mis_mask",  32'(bus.mem_write_mask), 32'd0);
    tick();
    check("sh_mis_err",  32'(bus.ls_resp_err), 32'd1);
    check("sh_mis_data", bus.ls_resp_data, 32'h0);
    drive_ls(1'b1, 32'h10, 1'b0, 2'b10, 1'b0, 32'h0);
    tick();
    check("lw_0x10_data", bus.ls_resp_data, 32'h0000AB00);
    check("lw_0x10_err",  32'(bus.ls_resp_err), 32'd0);

    // Misaligned fetch.
    drive_ls(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0);
    drive_if(1'b1, 32'h6);
    settle();
    check("if_mis_ready", 32'(bus.if_req_ready), 32'd1);
    check("if_mis_mask",  32'(bus.mem_write_mask), 32'd0);
    tick();
    check("if_mis_valid",    32'(bus.if_resp_valid), 32'd1);
    check("if_mis_err",      32'(bus.if_resp_err), 32'd1);
    check("if_mis_data",     bus.if_resp_data, 32'h0);
    check("if_mis_ls_valid", 32'(bus.ls_resp_valid), 32'd0);

    // Half/byte sign extension from {0x80,0x01} at 0x20, then illegal size.
    drive_if(1'b0, 32'h0);
    drive_ls(1'b1, 32'h20, 1'b0, 2'b01, 1'b1, 32'h0);
    tick();
    check("lh_signed", bus.ls_resp_data, 32'h00000180);
    drive_ls(1'b1, 32'h20, 1'b0, 2'b00, 1'b1, 32'h0);
    tick();
    check("lb_signed_0x20", bus.ls_resp_data, 32'hFFFFFF80);
    drive_ls(1'b1, 32'h0, 1'b0, 2'b11, 1'b0, 32'h0);
    tick();
    check("ill_size_err",  32'(bus.ls_resp_err), 32'd1);
    check("ill_size_data", bus.ls_resp_data, 32'h0);

    // Idle: response fields hold.
    drive_ls(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0);
    tick();
    check("idle_ls_valid", 32'(bus.ls_resp_valid), 32'd0);
    check("idle_ls_err",   32'(bus.ls_resp_err), 32'd1);
    check("idle_mem_addr", bus.mem_addr, 32'h0);

    // Fetch accepted, reset in the response cycle drops it.
    drive_if(1'b1, 32'h0);
    settle();
    check("pre_rst_if_ready", 32'(bus.if_req_ready), 32'd1);
    tick();
    reset = 1'b1;
    drive_ls(1'b1, 32'h4, 1'b0, 2'b10, 1'b0, 32'h0);
    settle();
    check("drop_if_valid", 32'(bus.if_resp_valid), 32'd0);
    check("drop_if_ready", 32'(bus.if_req_ready), 32'd0);
    check("drop_ls_ready", 32'(bus.ls_req_ready), 32'd0);
    tick();
    reset = 1'b0;
    settle();
    check("post_rst_ls_ready", 32'(bus.ls_req_ready), 32'd1);
    check("post_rst_if_ready", 32'(bus.if_req_ready), 32'd0);
    drive_if(1'b0, 32'h0);
    drive_ls(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0);
    tick();

    // Store in T, reset in T+1: write lands, response dropped, pointer back to LS.
    drive_ls(1'b1, 32'h30, 1'b1, 2'b00, 1'b0, 32'h00000055);
    settle();
    check("st_rst_mask", 32'(bus.mem_write_mask), 32'b0001);
    tick();
    reset = 1'b1;
    drive_ls(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0);
    settle();
    check("st_rst_ls_valid", 32'(bus.ls_resp_valid), 32'd0);
    tick();
    reset = 1'b0;
    drive_if(1'b1, 32'h0);
    drive_ls(1'b1, 32'h30, 1'b0, 2'b00, 1'b0, 32'h0);
    settle();
    check("st_rst_ls_wins", 32'(bus.ls_req_ready), 32'd1);
    tick();
    check("st_rst_ls_valid2", 32'(bus.ls_resp_valid), 32'd1);
    check("st_rst_data",      bus.ls_resp_data, 32'h00000055);

    drive_if(1'b0, 32'h0);
    drive_ls(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
